// File: rtl/ip_sequencer_pkg.sv
// Shared definitions for the instruction-pointer sequencer: GPR width and 3-bit state codes.
package ip_sequencer_pkg;

  localparam int GR_SIZE = 16;

  localparam logic [2:0] IP_SEQ_BOOT   = 3'd0;
  localparam logic [2:0] IP_SEQ_IDLE   = 3'd1;
  localparam logic [2:0] IP_SEQ_FETCH  = 3'd2;
  localparam logic [2:0] IP_SEQ_EXEC   = 3'd3;
  localparam logic [2:0] IP_SEQ_UPDATE = 3'd4;
  localparam logic [2:0] IP_SEQ_HALT   = 3'd5;

  typedef enum logic [2:0] {
    ST_BOOT   = IP_SEQ_BOOT,
    ST_IDLE   = IP_SEQ_IDLE,
    ST_FETCH  = IP_SEQ_FETCH,
    ST_EXEC   = IP_SEQ_EXEC,
    ST_UPDATE = IP_SEQ_UPDATE,
    ST_HALT   = IP_SEQ_HALT
  } seq_state_e;

endpackage

// File: rtl/ip_adjust_select.sv
// Priority mux for the next IP adjustment: trap > branch > sequential length.
// With FFR_IP_TRAP_EN defined it also exposes the trap return address.
module ip_adjust_select
  import ip_sequencer_pkg::*;
#(
  parameter int              IP_W        = GR_SIZE,
  parameter int              LEN_W       = 3,
  parameter logic [IP_W-1:0] TRAP_VECTOR = IP_W'(16'h0010)
) (
  input  logic [IP_W-1:0]  i_ip,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_branch,
  input  logic [IP_W-1:0]  i_offset,
  input  logic             i_trap,
`ifdef FFR_IP_TRAP_EN
  output logic [IP_W-1:0]  o_ret_addr,
`endif
  output logic [IP_W-1:0]  o_adjust
);

  logic [LEN_W-1:0] w_len_eff;
  logic [IP_W-1:0]  w_len_ext;

  // A zero length would leave the IP stuck, so it is promoted to one.
  always_comb begin
    if (i_len == {LEN_W{1'b0}}) begin
      w_len_eff = {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      w_len_eff = i_len;
    end
    w_len_ext = {{(IP_W-LEN_W){1'b0}}, w_len_eff};
  end

  // Trap redirect is expressed as a delta so the IP register only ever adds.
  always_comb begin
    if (i_trap) begin
      o_adjust = TRAP_VECTOR - i_ip;
    end else if (i_branch) begin
      o_adjust = i_offset;
    end else begin
      o_adjust = w_len_ext;
    end
  end

`ifdef FFR_IP_TRAP_EN
  assign o_ret_addr = i_ip + w_len_ext;
`endif

endmodule

// File: rtl/ip_sequencer.sv
// Fetch/execute/IP-update sequencer driving the InstructionPointer register.
// Optional trap redirect path is enabled by defining FFR_IP_TRAP_EN.
module ip_sequencer
  import ip_sequencer_pkg::*;
#(
  parameter int              IP_W        = GR_SIZE,
  parameter int              LEN_W       = 3,
  parameter logic [IP_W-1:0] TRAP_VECTOR = IP_W'(16'h0010)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [IP_W-1:0]  ipIn,
  output logic [IP_W-1:0]  ipAdjust,
  output logic             ipUpdateEnable,
  output logic             ipResetEnable,
  input  logic             run,
  output logic             fetchReq,
  input  logic             fetchAck,
  output logic             execStart,
  input  logic             execDone,
  input  logic [LEN_W-1:0] instrLen,
  input  logic             branchTaken,
  input  logic [IP_W-1:0]  branchOffset,
  input  logic             haltReq,
  input  logic             resume,
`ifdef FFR_IP_TRAP_EN
  input  logic             trapReq,
  output logic             trapAck,
  output logic [IP_W-1:0]  epc,
`endif
  output logic             halted
);

  seq_state_e      r_state;
  logic [IP_W-1:0] r_adjust;
  logic            r_upd_en;
  logic            r_rst_en;
  logic            r_fetch_req;
  logic            r_exec_start;
  logic            r_halted;

  seq_state_e      w_state_nxt;
  logic [IP_W-1:0] w_adjust_nxt;
  logic            w_upd_en_nxt;
  logic            w_rst_en_nxt;
  logic            w_fetch_req_nxt;
  logic            w_exec_start_nxt;
  logic            w_halted_nxt;
  logic [IP_W-1:0] w_sel_adjust;
  logic            w_trap;

`ifdef FFR_IP_TRAP_EN
  logic            r_trap_ack;
  logic [IP_W-1:0] r_epc;
  logic            w_trap_ack_nxt;
  logic [IP_W-1:0] w_ret_addr;

  assign w_trap  = trapReq;
  assign trapAck = r_trap_ack;
  assign epc     = r_epc;
`else
  assign w_trap  = 1'b0;
`endif

  ip_adjust_select #(
    .IP_W        (IP_W),
    .LEN_W       (LEN_W),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_adjust_select (
    .i_ip       (ipIn),
    .i_len      (instrLen),
    .i_branch   (branchTaken),
    .i_offset   (branchOffset),
    .i_trap     (w_trap),
`ifdef FFR_IP_TRAP_EN
    .o_ret_addr (w_ret_addr),
`endif
    .o_adjust   (w_sel_adjust)
  );

  // Next-state and next-output decode; halt outranks any IP update.
  always_comb begin
    w_state_nxt      = r_state;
    w_adjust_nxt     = r_adjust;
    w_upd_en_nxt     = 1'b0;
    w_rst_en_nxt     = 1'b0;
    w_fetch_req_nxt  = 1'b0;
    w_exec_start_nxt = 1'b0;
    w_halted_nxt     = 1'b0;
`ifdef FFR_IP_TRAP_EN
    w_trap_ack_nxt   = 1'b0;
`endif
    case (r_state)
      ST_BOOT: begin
        w_rst_en_nxt = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      ST_IDLE: begin
        if (run) begin
          w_fetch_req_nxt = 1'b1;
          w_state_nxt     = ST_FETCH;
        end else begin
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (fetchAck) begin
          w_exec_start_nxt = 1'b1;
          w_state_nxt      = ST_EXEC;
        end else begin
          w_fetch_req_nxt  = 1'b1;
        end
      end
      ST_EXEC: begin
        if (!execDone) begin
          w_state_nxt = ST_EXEC;
        end else if (haltReq) begin
          w_halted_nxt = 1'b1;
          w_state_nxt  = ST_HALT;
        end else begin
          w_adjust_nxt = w_sel_adjust;
          w_upd_en_nxt = 1'b1;
          w_state_nxt  = ST_UPDATE;
`ifdef FFR_IP_TRAP_EN
          w_trap_ack_nxt = trapReq;
`endif
        end
      end
      ST_UPDATE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_HALT: begin
        if (resume) begin
          w_state_nxt  = ST_IDLE;
        end else begin
          w_halted_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // State and registered outputs; reset drops any outstanding fetch at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_BOOT;
      r_adjust     <= {IP_W{1'b0}};
      r_upd_en     <= 1'b0;
      r_rst_en     <= 1'b0;
      r_fetch_req  <= 1'b0;
      r_exec_start <= 1'b0;
      r_halted     <= 1'b0;
`ifdef FFR_IP_TRAP_EN
      r_trap_ack   <= 1'b0;
      r_epc        <= {IP_W{1'b0}};
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_adjust     <= w_adjust_nxt;
      r_upd_en     <= w_upd_en_nxt;
      r_rst_en     <= w_rst_en_nxt;
      r_fetch_req  <= w_fetch_req_nxt;
      r_exec_start <= w_exec_start_nxt;
      r_halted     <= w_halted_nxt;
`ifdef FFR_IP_TRAP_EN
      r_trap_ack   <= w_trap_ack_nxt;
      if (w_trap_ack_nxt) begin
        r_epc <= w_ret_addr;
      end else begin
        r_epc <= r_epc;
      end
`endif
    end
  end

  assign ipAdjust       = r_adjust;
  assign ipUpdateEnable = r_upd_en;
  assign ipResetEnable  = r_rst_en;
  assign fetchReq       = r_fetch_req;
  assign execStart      = r_exec_start;
  assign halted         = r_halted;

endmodule

// File: tb/tb_ip_sequencer.sv
// Randomised bench for ip_sequencer: an IP register stand-in, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_ip_sequencer;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [15:0] ipIn;
  logic [15:0] ipAdjust;
  logic        ipUpdateEnable, ipResetEnable;
  logic        run = 1'b0;
  logic        fetchReq;
  logic        fetchAck = 1'b0;
  logic        execStart;
  logic        execDone = 1'b0;
  logic [2:0]  instrLen = 3'd0;
  logic        branchTaken = 1'b0;
  logic [15:0] branchOffset = 16'h0000;
  logic        haltReq = 1'b0;
  logic        resume = 1'b0;
  logic        halted;
`ifdef FFR_IP_TRAP_EN
  localparam logic [15:0] TRAP_VEC = 16'h0010;
  logic        trapReq = 1'b0;
  logic        trapAck;
  logic [15:0] epc;
`endif

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  ip_sequencer dut (
    .clk(clk), .resetN(resetN), .ipIn(ipIn), .ipAdjust(ipAdjust),
    .ipUpdateEnable(ipUpdateEnable), .ipResetEnable(ipResetEnable),
    .run(run), .fetchReq(fetchReq), .fetchAck(fetchAck), .execStart(execStart),
    .execDone(execDone), .instrLen(instrLen), .branchTaken(branchTaken),
    .branchOffset(branchOffset), .haltReq(haltReq), .resume(resume),
`ifdef FFR_IP_TRAP_EN
    .trapReq(trapReq), .trapAck(trapAck), .epc(epc),
`endif
    .halted(halted)
  );

  // Stand-in for the InstructionPointer register: clears or adds the delta.
  logic [15:0] ip_q = 16'hBEEF;
  always @(posedge clk) begin
    if (ipResetEnable) ip_q <= 16'h0000;
    else if (ipUpdateEnable) ip_q <= ip_q + ipAdjust;
  end
  assign ipIn = ip_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the loop as "what is outstanding": a boot pulse, a fetch request,
  // an instruction in execution, an update in flight, or a halt.
  logic        e_boot = 1'b1, e_rst_en = 1'b0, e_req = 1'b0, e_start = 1'b0;
  logic        e_upd = 1'b0, e_halted = 1'b0, m_exec = 1'b0, m_ip_known = 1'b0;
  logic        e_tack = 1'b0;
  logic [15:0] e_adj = 16'h0000, e_epc = 16'h0000, m_ip = 16'h0000, m_target = 16'h0000;
  logic        m_idle, m_trap_in;
  logic [15:0] m_eff, m_tgt;

  always_comb begin
    m_idle = !e_boot && !e_req && !m_exec && !e_upd && !e_halted;
    m_eff  = (instrLen == 3'd0) ? 16'd1 : {13'd0, instrLen};
`ifdef FFR_IP_TRAP_EN
    m_trap_in = trapReq;
`else
    m_trap_in = 1'b0;
`endif
    if (m_trap_in) m_tgt = 16'h0010;
    else if (branchTaken) m_tgt = m_ip + branchOffset;
    else m_tgt = m_ip + m_eff;
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      e_boot <= 1'b1; e_rst_en <= 1'b0; e_req <= 1'b0; e_start <= 1'b0;
      e_upd <= 1'b0; e_halted <= 1'b0; m_exec <= 1'b0; e_adj <= 16'h0000;
      e_tack <= 1'b0; e_epc <= 16'h0000;
    end else begin
      e_boot <= 1'b0; e_rst_en <= e_boot; e_start <= 1'b0; e_upd <= 1'b0; e_tack <= 1'b0;
      if (e_rst_en) begin m_ip <= 16'h0000; m_ip_known <= 1'b1; end
      else if (e_upd) m_ip <= m_target;
      if (m_idle && run) e_req <= 1'b1;
      if (e_req && fetchAck) begin e_req <= 1'b0; e_start <= 1'b1; m_exec <= 1'b1; end
      if (m_exec && execDone) begin
        m_exec <= 1'b0;
        if (haltReq) e_halted <= 1'b1;
        else begin
          e_upd <= 1'b1; m_target <= m_tgt; e_adj <= m_tgt - m_ip;
          if (m_trap_in) begin e_tack <= 1'b1; e_epc <= m_ip + m_eff; end
        end
      end
      if (e_halted && resume) e_halted <= 1'b0;
    end
  end

  // Single compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ipResetEnable", {31'd0, ipResetEnable}, {31'd0, e_rst_en});
      chk("fetchReq", {31'd0, fetchReq}, {31'd0, e_req});
      chk("execStart", {31'd0, execStart}, {31'd0, e_start});
      chk("ipUpdateEnable", {31'd0, ipUpdateEnable}, {31'd0, e_upd});
      chk("halted", {31'd0, halted}, {31'd0, e_halted});
      chk("ipAdjust", {16'd0, ipAdjust}, {16'd0, e_adj});
      if (m_ip_known) chk("ip", {16'd0, ip_q}, {16'd0, m_ip});
`ifdef FFR_IP_TRAP_EN
      chk("trapAck", {31'd0, trapAck}, {31'd0, e_tack});
      chk("epc", {16'd0, epc}, {16'd0, e_epc});
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!fetchReq && n < 50) begin tick(); n++; end
    chk("fetch_req_seen", {31'd0, fetchReq}, 32'd1);
  endtask

  // Completes one instruction; returns just after the edge sampling execDone.
  task automatic do_instr(input logic [2:0] len, input logic br, input logic [15:0] off,
                          input logic hlt, input logic trp, input int delay,
                          input logic drop_run, output int req_cycles);
    wait_req();
    req_cycles = fetchReq ? 1 : 0;
    if (drop_run) run = 1'b0;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (fetchReq) req_cycles++;
    end
    fetchAck = 1'b1; tick(); fetchAck = 1'b0;
    execDone = 1'b1; instrLen = len; branchTaken = br; branchOffset = off; haltReq = hlt;
`ifdef FFR_IP_TRAP_EN
    trapReq = trp;
`endif
    tick();
    execDone = 1'b0; branchTaken = 1'b0; haltReq = 1'b0;
`ifdef FFR_IP_TRAP_EN
    trapReq = 1'b0;
`endif
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    #3 resetN = 1'b0;
    cmp_en = 1'b1;
    tick(); tick();
    run = 1'b1;
    resetN = 1'b1;
    // Boot pulse, then first sequential instruction of length 2.
    tick();
    chk("boot_pulse", {31'd0, ipResetEnable}, 32'd1);
    tick();
    chk("boot_pulse_end", {31'd0, ipResetEnable}, 32'd0);
    chk("ip_after_boot", {16'd0, ip_q}, 32'h0000);
    do_instr(3'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 1'b0, rc);
    chk("seq_upd_en", {31'd0, ipUpdateEnable}, 32'd1);
    chk("seq_adjust", {16'd0, ipAdjust}, 32'h0002);
    tick();
    chk("seq_upd_en_drop", {31'd0, ipUpdateEnable}, 32'd0);
    chk("seq_ip", {16'd0, ip_q}, 32'h0002);
    chk("refetch_not_early", {31'd0, fetchReq}, 32'd0);
    tick();
    chk("refetch_latency", {31'd0, fetchReq}, 32'd1);
    // Branches, including backwards and wrap-around.
    do_instr(3'd1, 1'b1, 16'h0006, 1'b0, 1'b0, 0, 1'b0, rc); tick();
    chk("br_ip_8", {16'd0, ip_q}, 32'h0008);
    do_instr(3'd4, 1'b1, 16'hFFFA, 1'b0, 1'b0, 2, 1'b0, rc);
    chk("br_back_adjust", {16'd0, ipAdjust}, 32'hFFFA);
    tick();
    chk("br_back_ip", {16'd0, ip_q}, 32'h0002);
    do_instr(3'd1, 1'b1, 16'hFFFC, 1'b0, 1'b0, 0, 1'b0, rc); tick();
    chk("br_ip_fffe", {16'd0, ip_q}, 32'hFFFE);
    do_instr(3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, rc);
    chk("wrap_adjust", {16'd0, ipAdjust}, 32'h0003);
    tick();
    chk("wrap_ip", {16'd0, ip_q}, 32'h0001);
    do_instr(3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, rc);
    chk("len0_adjust", {16'd0, ipAdjust}, 32'h0001);
    tick();
    chk("len0_ip", {16'd0, ip_q}, 32'h0002);
    // Slow acknowledge with run dropped mid-request.
    do_instr(3'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 5, 1'b1, rc);
    chk("req_hold_cycles", rc, 32'd6);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_stall", {31'd0, fetchReq}, 32'd0);
    end
    chk("stall_ip", {16'd0, ip_q}, 32'h0004);
    run = 1'b1;
    // Halt together with a branch: halt wins, IP untouched.
    do_instr(3'd2, 1'b1, 16'h0100, 1'b1, 1'b0, 1, 1'b0, rc);
    chk("halt_no_update", {31'd0, ipUpdateEnable}, 32'd0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    execDone = 1'b1; tick(); execDone = 1'b0; tick(); tick();
    chk("halt_ip_kept", {16'd0, ip_q}, 32'h0004);
    chk("halt_no_fetch", {31'd0, fetchReq}, 32'd0);
    resume = 1'b1; tick(); resume = 1'b0;
    chk("resume_clears", {31'd0, halted}, 32'd0);
    tick();
    chk("resume_fetch", {31'd0, fetchReq}, 32'd1);
    // Reset while a fetch is outstanding.
    resetN = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, fetchReq}, 32'd0);
    tick();
    resetN = 1'b1;
    tick();
    chk("reboot_pulse", {31'd0, ipResetEnable}, 32'd1);
    tick();
    chk("reboot_ip", {16'd0, ip_q}, 32'h0000);
`ifdef FFR_IP_TRAP_EN
    do_instr(3'd1, 1'b1, 16'h0020, 1'b0, 1'b0, 0, 1'b0, rc); tick();
    chk("trap_setup_ip", {16'd0, ip_q}, 32'h0020);
    do_instr(3'd1, 1'b1, 16'h0004, 1'b0, 1'b1, 1, 1'b0, rc);
    chk("trap_adjust", {16'd0, ipAdjust}, 32'hFFF0);
    chk("trap_ack", {31'd0, trapAck}, 32'd1);
    tick();
    chk("trap_ack_drop", {31'd0, trapAck}, 32'd0);
    chk("trap_ip", {16'd0, ip_q}, {16'd0, TRAP_VEC});
    chk("trap_epc", {16'd0, epc}, 32'h0021);
`endif
    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      resetN       = ($urandom_range(0, 199) != 0);
      run          = ($urandom_range(0, 9) != 0);
      fetchAck     = ($urandom_range(0, 9) < 4);
      execDone     = ($urandom_range(0, 9) < 3);
      instrLen     = 3'($urandom_range(0, 7));
      branchTaken  = ($urandom_range(0, 9) < 3);
      branchOffset = 16'($urandom);
      haltReq      = ($urandom_range(0, 19) < 2);
      resume       = ($urandom_range(0, 3) == 0);
`ifdef FFR_IP_TRAP_EN
      trapReq      = ($urandom_range(0, 6) == 0);
`endif
      tick();
    end
    resetN = 1'b1; run = 1'b0; fetchAck = 1'b0; execDone = 1'b0; resume = 1'b0;
    haltReq = 1'b0; branchTaken = 1'b0;
`ifdef FFR_IP_TRAP_EN
    trapReq = 1'b0;
`endif
    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_sequencer.md
Name: ip_sequencer

Overview:
- Sequencing controller for the InstructionPointer register. It drives that register's `adjust`, `updateEnable` and `resetEnable` inputs.
- Runs the fetch → execute → IP-update loop:
  - issues a fetch request/acknowledge handshake to instruction memory at the current IP;
  - waits for the execution unit's completion report;
  - applies one of three IP adjustments: sequential advance, relative branch, or trap redirect.
- Sits between the IP register, instruction memory port and execution unit, at the core top level.

Parameters:
- IP_W, 16, IP/GPR width in bits; must equal the width of `GR_SIZE` from Defines.v.
- LEN_W, 3, width of instruction-length field (bytes/words per instruction).
- TRAP_VECTOR, 16'h0010, absolute trap handler address (used only with FFR_IP_TRAP_EN).

Ports:
- clk  in  1  core clock, rising-edge.
- resetN  in  1  asynchronous active-low reset.
- ipIn  in  IP_W  current IP value (InstructionPointer `out`).
- ipAdjust  out  IP_W  signed adjustment to InstructionPointer `adjust`.
- ipUpdateEnable  out  1  to InstructionPointer `updateEnable`.
- ipResetEnable  out  1  to InstructionPointer `resetEnable`.
- run  in  1  level; 0 = do not start a new fetch.
- fetchReq  out  1  fetch request; fetch address is ipIn.
- fetchAck  in  1  memory accepted/returned instruction.
- execStart  out  1  one-cycle pulse: fetched instruction valid for execution.
- execDone  in  1  one-cycle pulse: execution finished, result fields valid.
- instrLen  in  LEN_W  length of completed instruction.
- branchTaken  in  1  qualify branchOffset.
- branchOffset  in  IP_W  signed relative branch offset.
- haltReq  in  1  executed instruction was HALT.
- resume  in  1  leave HALT state.
- halted  out  1  high while in HALT.

Behaviour:
- States: BOOT, IDLE, FETCH, EXEC, UPDATE, HALT. Outputs are registered.
- Async reset (resetN=0):
  - state=BOOT;
  - ipAdjust=0;
  - ipUpdateEnable, ipResetEnable, fetchReq, execStart, halted = 0.
- BOOT:
  - asserts ipResetEnable for exactly one cycle (the IP clears synchronously on that edge);
  - then goes to IDLE.
- IDLE:
  - if run=1, go to FETCH and raise fetchReq on the next cycle;
  - otherwise stay in IDLE.
- FETCH:
  - fetchReq held high until the cycle fetchAck=1;
  - run is not re-checked once fetchReq is raised;
  - on ack: fetchReq=0, execStart pulses 1 cycle, go to EXEC.
  - fetchAck outside FETCH is ignored.
- EXEC: wait for execDone. On execDone, priority is haltReq > trap (optional) > branch > sequential:
  - haltReq: go to HALT, halted=1, no IP update.
  - branchTaken: ipAdjust<=branchOffset.
  - else: ipAdjust<=zero-extended instrLen. instrLen==0 is treated as 1 (no livelock).
  - ipUpdateEnable<=1 for exactly one cycle, then go to UPDATE.
- UPDATE:
  - ipUpdateEnable returns to 0;
  - go to IDLE; the IP is valid this cycle.
- Latency: execDone at edge N → ipUpdateEnable high in N+1 → IP new at N+2 → fetchReq high at N+3 (if run=1).
- Arithmetic: all IP arithmetic is modulo 2^IP_W. Wrap past all-ones, or a negative branch below 0, wraps silently.
- HALT:
  - halted=1, no fetches;
  - resume=1 → halted=0, go to IDLE;
  - execDone in HALT is ignored.
- Reset mid-operation: immediate return to BOOT. An outstanding fetchReq is dropped; memory must tolerate an abandoned request.
- Simultaneous haltReq+branchTaken: the halt wins and the IP is not updated.

Optional Feature:
- FFR_IP_TRAP_EN. When defined, adds:
  - ports trapReq (in 1), trapAck (out 1), epc (out IP_W);
  - a trapReq sampled with execDone wins over branch/sequential but not over halt;
  - ipAdjust<=TRAP_VECTOR-ipIn (mod 2^IP_W);
  - epc<=ipIn+instrLen (the return address);
  - trapAck pulses in the same cycle as ipUpdateEnable;
  - epc resets to 0.
- When undefined: the ports are absent and the trap path is removed.

Decomposition:
- Shared package/Defines.v holds the state encoding constants (IP_SEQ_BOOT..IP_SEQ_HALT, 3-bit) and the `GR_SIZE` width.
- One natural sub-module, ip_adjust_select: a combinational priority mux producing the next ipAdjust from branch/trap/len inputs. The FSM stays in ip_sequencer.

Test Plan:
- Reset then run=1, fetchAck one cycle after fetchReq, execDone with instrLen=2, no branch → ipResetEnable pulse once, ipAdjust=2, ipUpdateEnable 1 cycle, IP=2, second fetchReq 3 cycles after execDone.
- IP=0x0008, branchTaken=1, branchOffset=0xFFFA (-6) → ipAdjust=0xFFFA, IP=0x0002; repeat at IP=0xFFFE with instrLen=3 → IP wraps to 0x0001.
- fetchAck delayed 5 cycles, run dropped to 0 mid-request → fetchReq held 6 cycles continuously, then stall in IDLE after the update.
- haltReq=1 together with branchTaken=1 → no ipUpdateEnable, halted=1; resume pulse → halted=0, next fetch occurs.
- resetN low while fetchReq=1 in FETCH → fetchReq=0 asynchronously, BOOT ipResetEnable pulse after release.
- (FFR_IP_TRAP_EN) IP=0x0020, instrLen=1, trapReq+branchTaken at execDone → ipAdjust=0xFFF0, IP=0x0010, epc=0x0021, trapAck 1 cycle.
